// File: rtl/vector_bank_memory_if.sv
// Request/response bundle for vector_bank_memory: port A (vector/scalar load-store),
// port B (scalar read-only) and the clear-complete flag.
interface vector_bank_memory_if #(
    parameter int LANES  = 6,
    parameter int ELEM_W = 12,
    parameter int ADDR_W = 19
) ();
    logic                      a_valid;
    logic                      a_ready;
    logic                      a_vector;
    logic                      a_we;
    logic [ADDR_W-1:0]         a_addr;
    logic [LANES-1:0]          a_wmask;
    logic [LANES*ELEM_W-1:0]   a_wdata;
    logic                      a_rvalid;
    logic [LANES*ELEM_W-1:0]   a_rdata;
    logic                      a_err;
    logic                      b_valid;
    logic [ADDR_W-1:0]         b_addr;
    logic                      b_rvalid;
    logic [ELEM_W-1:0]         b_rdata;
    logic                      init_done;

    modport master (
        output a_valid, a_vector, a_we, a_addr, a_wmask, a_wdata, b_valid, b_addr,
        input  a_ready, a_rvalid, a_rdata, a_err, b_rvalid, b_rdata, init_done
    );

    modport slave (
        input  a_valid, a_vector, a_we, a_addr, a_wmask, a_wdata, b_valid, b_addr,
        output a_ready, a_rvalid, a_rdata, a_err, b_rvalid, b_rdata, init_done
    );
endinterface

// File: rtl/vector_bank_memory.sv
// Banked vector memory: LANES interleaved single-element banks allow unaligned vector
// access in one cycle; 2-cycle registered reads, post-reset zero-fill of every row.
module vector_bank_memory #(
    parameter int LANES      = 6,
    parameter int ELEM_W     = 12,
    parameter int BANK_DEPTH = 1024,
    parameter int ADDR_W     = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vector_bank_memory_if.slave  bus
);
    // state   | meaning
    // S_CLEAR | zero-filling one row of every bank per cycle, port A/B closed
    // S_RUN   | normal operation, init_done and a_ready held high

    localparam int TOTAL = LANES * BANK_DEPTH;
    localparam int BW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int RW    = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam logic [ADDR_W:0] TOTAL_X = (ADDR_W+1)'(TOTAL);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                      state, state_nxt;
    logic [RW-1:0]               clr_row, clr_row_nxt;

    logic                        a_fire, b_req;
    logic                        q_a_fire, q_a_we, q_a_vec, q_b_req;
    logic [ADDR_W-1:0]           q_a_addr, q_b_addr;
    logic [LANES-1:0]            q_a_wmask;
    logic [LANES-1:0][ELEM_W-1:0] q_a_wdata;

    logic                        a_oor, b_oor;
    logic [BW-1:0]               a_base, b_base, lane;
    logic [RW-1:0]               a_row, a_row_inc, b_row;
    logic [RW-1:0]               bank_rrow [LANES];
    logic [RW-1:0]               bank_wrow [LANES];
    logic [LANES-1:0]            bank_we;
    logic [LANES-1:0][ELEM_W-1:0] bank_wdata, a_bank_q, b_bank_q, a_rot;

    logic                        s1_a_rd, s1_a_err, s1_a_vec, s1_b_rd, s1_b_oor;
    logic [BW-1:0]               s1_a_base, s1_b_base;
    logic [BW:0]                 idx;

    assign bus.a_ready   = (state == S_RUN);
    assign bus.init_done = (state == S_RUN);
    assign a_fire        = bus.a_valid && bus.a_ready;
    assign b_req         = bus.b_valid && (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_CLEAR;
            clr_row <= '0;
        end else begin
            state   <= state_nxt;
            clr_row <= clr_row_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_row_nxt = clr_row;
        case (state)
            S_CLEAR: begin
                if (clr_row == RW'(BANK_DEPTH-1)) begin
                    state_nxt   = S_RUN;
                    clr_row_nxt = '0;
                end else begin
                    clr_row_nxt = clr_row + RW'(1);
                end
            end
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Bank j serves lane (j - base) mod LANES; banks below the base bank sit one row further on.
    always_comb begin
        a_oor      = {1'b0, q_a_addr} >= TOTAL_X;
        b_oor      = {1'b0, q_b_addr} >= TOTAL_X;
        a_base     = BW'(q_a_addr % ADDR_W'(LANES));
        a_row      = RW'(q_a_addr / ADDR_W'(LANES));
        b_base     = BW'(q_b_addr % ADDR_W'(LANES));
        b_row      = RW'(q_b_addr / ADDR_W'(LANES));
        a_row_inc  = (a_row == RW'(BANK_DEPTH-1)) ? '0 : a_row + RW'(1);
        lane       = '0;
        bank_we    = '0;
        bank_wdata = '0;
        bank_rrow  = '{default: '0};
        bank_wrow  = '{default: '0};
        for (int j = 0; j < LANES; j++) begin
            if (BW'(j) >= a_base) lane = BW'(j) - a_base;
            else                  lane = BW'(j) + BW'(LANES) - a_base;
            bank_rrow[j] = (BW'(j) < a_base) ? a_row_inc : a_row;
            if (state == S_CLEAR) begin
                bank_we[j]    = 1'b1;
                bank_wrow[j]  = clr_row;
            end else begin
                bank_we[j]    = q_a_fire && q_a_we && !a_oor && q_a_wmask[lane]
                                && (q_a_vec || lane == '0);
                bank_wrow[j]  = bank_rrow[j];
                bank_wdata[j] = q_a_wdata[lane];
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_bank
        logic [ELEM_W-1:0] mem [BANK_DEPTH];
        logic [ELEM_W-1:0] rd_a, rd_b;
        always_ff @(posedge clk) begin
            if (bank_we[j]) mem[bank_wrow[j]] <= bank_wdata[j];
            rd_a <= mem[bank_rrow[j]];
            rd_b <= mem[b_row];
        end
        assign a_bank_q[j] = rd_a;
        assign b_bank_q[j] = rd_b;
    end

    always_comb begin
        a_rot = '0;
        idx   = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = {1'b0, s1_a_base} + (BW+1)'(k);
            if (idx >= (BW+1)'(LANES)) idx = idx - (BW+1)'(LANES);
            if (!s1_a_err && (s1_a_vec || k == 0)) a_rot[k] = a_bank_q[idx[BW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a_fire     <= 1'b0;
            q_a_we       <= 1'b0;
            q_a_vec      <= 1'b0;
            q_a_addr     <= '0;
            q_a_wmask    <= '0;
            q_a_wdata    <= '0;
            q_b_req      <= 1'b0;
            q_b_addr     <= '0;
            s1_a_rd      <= 1'b0;
            s1_a_err     <= 1'b0;
            s1_a_vec     <= 1'b0;
            s1_a_base    <= '0;
            s1_b_rd      <= 1'b0;
            s1_b_oor     <= 1'b0;
            s1_b_base    <= '0;
            bus.a_rvalid <= 1'b0;
            bus.a_err    <= 1'b0;
            bus.a_rdata  <= '0;
            bus.b_rvalid <= 1'b0;
            bus.b_rdata  <= '0;
        end else begin
            q_a_fire     <= a_fire;
            q_a_we       <= bus.a_we;
            q_a_vec      <= bus.a_vector;
            q_a_addr     <= bus.a_addr;
            q_a_wmask    <= bus.a_wmask;
            q_a_wdata    <= bus.a_wdata;
            q_b_req      <= b_req;
            q_b_addr     <= bus.b_addr;
            s1_a_rd      <= q_a_fire && !q_a_we;
            s1_a_err     <= q_a_fire && a_oor;
            s1_a_vec     <= q_a_vec;
            s1_a_base    <= a_base;
            s1_b_rd      <= q_b_req;
            s1_b_oor     <= b_oor;
            s1_b_base    <= b_base;
            bus.a_rvalid <= s1_a_rd;
            bus.a_err    <= s1_a_err;
            if (s1_a_rd) bus.a_rdata <= a_rot;
            bus.b_rvalid <= s1_b_rd;
            if (s1_b_rd) bus.b_rdata <= s1_b_oor ? '0 : b_bank_q[s1_b_base];
        end
    end
endmodule
